// File: rtl/ccc_apb_cfg_pkg.sv
// Shared types and widths for the CCC dynamic-configuration APB master.
package ccc_apb_cfg_pkg;

  localparam int CCC_ADDR_W = 6;
  localparam int CCC_DATA_W = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BUSY = 3'd1,
    SETUP     = 3'd2,
    ACCESS    = 3'd3,
    RB_SETUP  = 3'd4,
    RB_ACCESS = 3'd5,
    RESP      = 3'd6
  } cfg_state_e;

endpackage

// File: rtl/ccc_apb_cfg_master_if.sv
// Command/response handshake plus CCC APB configuration port, bundled.
interface ccc_apb_cfg_master_if;
  import ccc_apb_cfg_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [CCC_ADDR_W-1:0] cmd_addr;
  logic [CCC_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [CCC_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [CCC_ADDR_W-1:0] paddr;
  logic [CCC_DATA_W-1:0] pwdata;
  logic [CCC_DATA_W-1:0] prdata;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, busy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, busy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/ccc_lock_monitor.sv
// CCC LOCK conditioning: 2-FF sync, saturating filter, stable flag and sticky loss flag.
module ccc_lock_monitor
  import ccc_apb_cfg_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 16
) (
  input  logic pclk_i,
  input  logic reset_i,
  input  logic lock_i,
  input  logic lock_lost_clr_i,
  output logic lock_stable_o,
  output logic lock_lost_o
);

  localparam logic [CNT_W-1:0] FILT = CNT_W'(LOCK_FILTER);

  logic             lock_meta_q, lock_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable;
  logic             stable_prev_q;
  logic             lost_q, lost_d;

  assign stable = (cnt_q == FILT);

  always_comb begin
    cnt_d = cnt_q;
    if (!lock_s_q)          cnt_d = '0;
    else if (cnt_q != FILT) cnt_d = cnt_q + 1'b1;
  end

  // A new loss event takes priority over a coincident clear.
  assign lost_d = (stable_prev_q & ~stable) | (lost_q & ~lock_lost_clr_i);

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      cnt_q         <= '0;
      stable_prev_q <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      lock_meta_q   <= lock_i;
      lock_s_q      <= lock_meta_q;
      cnt_q         <= cnt_d;
      stable_prev_q <= stable;
      lost_q        <= lost_d;
    end
  end

  assign lock_stable_o = stable;
  assign lock_lost_o   = lost_q;

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// APB3-style initiator for the CCC/PLL dynamic-configuration port plus lock conditioning.
// Optional write readback verify: define CCC_APB_CFG_READBACK_EN.
//
// state     | meaning
// IDLE      | ready for a command
// WAIT_BUSY | waiting for synchronized BUSY low, timeout running
// SETUP     | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS    | APB access phase (PSEL=1, PENABLE=1)
// RB_SETUP  | readback setup phase after a write
// RB_ACCESS | readback access phase
// RESP      | one-cycle response strobe
module ccc_apb_cfg_master
  import ccc_apb_cfg_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned LOCK_FILTER  = 16
) (
  input  logic                  pclk_i,
  input  logic                  reset_i,
  ccc_apb_cfg_master_if.master  bus,
  input  logic                  lock_i,
  input  logic                  lock_lost_clr_i,
  output logic                  lock_stable_o,
  output logic                  lock_lost_o
);

  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(BUSY_TIMEOUT - 1);

  cfg_state_e            state_q, state_d;
  logic                  busy_meta_q, busy_s_q;
  logic [CNT_W-1:0]      tmo_q, tmo_d;
  logic                  hold_write_q, hold_write_d;
  logic [CCC_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [CCC_DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [CCC_ADDR_W-1:0] paddr_q, paddr_d;
  logic [CCC_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CCC_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  cmd_ready_q;
  logic                  psel, penable;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          hold_write_d = bus.cmd_write;
          hold_addr_d  = bus.cmd_addr;
          hold_wdata_d = bus.cmd_wdata;
          tmo_d        = TMO_LOAD;
          rdata_d      = '0;
          err_d        = 1'b0;
          state_d      = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!busy_s_q) begin
          paddr_d  = hold_addr_q;
          pwrite_d = hold_write_q;
          pwdata_d = hold_wdata_q;
          state_d  = SETUP;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (!hold_write_q) begin
          rdata_d = bus.prdata;
          state_d = RESP;
        end else begin
`ifdef CCC_APB_CFG_READBACK_EN
          pwrite_d = 1'b0;
          state_d  = RB_SETUP;
`else
          state_d  = RESP;
`endif
        end
      end
`ifdef CCC_APB_CFG_READBACK_EN
      RB_SETUP: state_d = RB_ACCESS;
      RB_ACCESS: begin
        rdata_d = bus.prdata;
        err_d   = (bus.prdata != hold_wdata_q);
        state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      busy_meta_q  <= 1'b0;
      busy_s_q     <= 1'b0;
      tmo_q        <= '0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_meta_q  <= bus.busy;
      busy_s_q     <= busy_meta_q;
      tmo_q        <= tmo_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cmd_ready_q  <= (state_d == IDLE);
    end
  end

  // Decoded from the async-reset state register so a reset drops them at once.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    unique case (state_q)
      SETUP:     psel = 1'b1;
      ACCESS:    begin psel = 1'b1; penable = 1'b1; end
`ifdef CCC_APB_CFG_READBACK_EN
      RB_SETUP:  psel = 1'b1;
      RB_ACCESS: begin psel = 1'b1; penable = 1'b1; end
`endif
      default:   ;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.psel      = psel;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

  ccc_lock_monitor #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_monitor (
    .pclk_i          (pclk_i),
    .reset_i         (reset_i),
    .lock_i          (lock_i),
    .lock_lost_clr_i (lock_lost_clr_i),
    .lock_stable_o   (lock_stable_o),
    .lock_lost_o     (lock_lost_o)
  );

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Directed self-checking bench for ccc_apb_cfg_master (BUSY_TIMEOUT=4, LOCK_FILTER=16).
module tb_ccc_apb_cfg_master;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic lock = 1'b0;
  logic lock_lost_clr = 1'b0;
  logic lock_stable, lock_lost;
  int   tests = 0;
  int   fails = 0;

  ccc_apb_cfg_master_if bif();

  ccc_apb_cfg_master #(
    .BUSY_TIMEOUT (4),
    .LOCK_FILTER  (16)
  ) dut (
    .pclk_i          (pclk),
    .reset_i         (rst),
    .bus             (bif),
    .lock_i          (lock),
    .lock_lost_clr_i (lock_lost_clr),
    .lock_stable_o   (lock_stable),
    .lock_lost_o     (lock_lost)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Drives one command; returns one cycle after the handshake edge (N+1).
  task automatic issue(input bit wr, input logic [5:0] a, input logic [7:0] d);
    int n = 0;
    while (bif.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tests++;
    if (bif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: cmd_ready=%b required 1 within 20 cycles", bif.cmd_ready);
    end
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    tick(); tick();
    outs = {bif.cmd_ready, bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.psel, bif.penable,
            bif.pwrite, bif.paddr, bif.pwdata, lock_stable, lock_lost};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bif.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", bif.cmd_ready);
    end
  endtask

  task automatic test_write();
    bif.busy = 1'b0; bif.prdata = 8'h5C;
    issue(1'b1, 6'h2A, 8'h5C);
    tests++;
    if (bif.psel !== 1'b0) begin
      fails++; $display("FAIL wr_wait_psel: psel=%b required 0", bif.psel);
    end
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite, bif.paddr} !== {1'b1, 1'b0, 1'b1, 6'h2A}) begin
      fails++;
      $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h required 1 0 1 2a",
               bif.psel, bif.penable, bif.pwrite, bif.paddr);
    end
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite, bif.paddr, bif.pwdata} !==
        {1'b1, 1'b1, 1'b1, 6'h2A, 8'h5C}) begin
      fails++;
      $display("FAIL wr_access: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required 1 1 1 2a 5c",
               bif.psel, bif.penable, bif.pwrite, bif.paddr, bif.pwdata);
    end
`ifdef CCC_APB_CFG_READBACK_EN
    tick(); tick();
`endif
    tick();
    tests++;
`ifdef CCC_APB_CFG_READBACK_EN
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {1'b1, 1'b0, 8'h5C}) begin
`else
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin
`endif
      fails++;
      $display("FAIL wr_resp: rsp_valid=%b rsp_err=%b rsp_rdata=%h", bif.rsp_valid, bif.rsp_err,
               bif.rsp_rdata);
    end
    tick();
    tests++;
    if ({bif.rsp_valid, bif.psel, bif.cmd_ready, bif.paddr, bif.pwdata} !==
        {1'b0, 1'b0, 1'b1, 6'h2A, 8'h5C}) begin
      fails++;
      $display("FAIL wr_idle_hold: rsp_valid=%b psel=%b cmd_ready=%b paddr=%h pwdata=%h required 0 0 1 2a 5c",
               bif.rsp_valid, bif.psel, bif.cmd_ready, bif.paddr, bif.pwdata);
    end
  endtask

  task automatic test_read();
    bif.prdata = 8'hA5;
    issue(1'b0, 6'h07, 8'h11);
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite, bif.paddr} !== {1'b1, 1'b0, 1'b0, 6'h07}) begin
      fails++;
      $display("FAIL rd_setup: psel=%b penable=%b pwrite=%b paddr=%h required 1 0 0 07",
               bif.psel, bif.penable, bif.pwrite, bif.paddr);
    end
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite} !== 3'b110) begin
      fails++;
      $display("FAIL rd_access: psel=%b penable=%b pwrite=%b required 1 1 0",
               bif.psel, bif.penable, bif.pwrite);
    end
    tick();
    tests++;
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL rd_resp: rsp_valid=%b rsp_err=%b rsp_rdata=%h required 1 0 a5",
               bif.rsp_valid, bif.rsp_err, bif.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_busy_timeout();
    bif.busy = 1'b1;
    tick(); tick(); tick();
    issue(1'b1, 6'h10, 8'h99);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({bif.psel, bif.rsp_valid} !== 2'b00) begin
        fails++;
        $display("FAIL tmo_wait%0d: psel=%b rsp_valid=%b required 0 0", i, bif.psel, bif.rsp_valid);
      end
      tick();
    end
    tests++;
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.psel} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL tmo_resp: rsp_valid=%b rsp_err=%b rsp_rdata=%h psel=%b required 1 1 00 0",
               bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.psel);
    end
    tick();
  endtask

  task automatic test_busy_release();
    bif.prdata = 8'h66;
    issue(1'b0, 6'h05, 8'h00);
    bif.busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bif.psel !== 1'b0) begin
        fails++; $display("FAIL brel_wait%0d: psel=%b required 0", i, bif.psel);
      end
      tick();
    end
    tests++;
    if ({bif.psel, bif.penable, bif.paddr} !== {1'b1, 1'b0, 6'h05}) begin
      fails++;
      $display("FAIL brel_setup: psel=%b penable=%b paddr=%h required 1 0 05",
               bif.psel, bif.penable, bif.paddr);
    end
    tick(); tick();
    tests++;
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {1'b1, 1'b0, 8'h66}) begin
      fails++;
      $display("FAIL brel_resp: rsp_valid=%b rsp_err=%b rsp_rdata=%h required 1 0 66",
               bif.rsp_valid, bif.rsp_err, bif.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bif.prdata = 8'h44;
    issue(1'b1, 6'h01, 8'h44);
    while (bif.rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    tests++;
    if (bif.rsp_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_rsp_wait: rsp_valid=%b required 1 within 10 cycles", bif.rsp_valid);
    end
    bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_addr = 6'h02;
    tick();
    tests++;
    if (bif.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: cmd_ready=%b required 1 right after response", bif.cmd_ready);
    end
    tick();
    bif.cmd_valid = 1'b0;
    tests++;
    if (bif.cmd_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: cmd_ready=%b required 0", bif.cmd_ready);
    end
    tick();
    tests++;
    if ({bif.psel, bif.pwrite, bif.paddr} !== {1'b1, 1'b0, 6'h02}) begin
      fails++;
      $display("FAIL b2b_setup: psel=%b pwrite=%b paddr=%h required 1 0 02", bif.psel, bif.pwrite,
               bif.paddr);
    end
    tick(); tick();
    tests++;
    if ({bif.rsp_valid, bif.rsp_rdata} !== {1'b1, 8'h44}) begin
      fails++;
      $display("FAIL b2b_resp: rsp_valid=%b rsp_rdata=%h required 1 44", bif.rsp_valid, bif.rsp_rdata);
    end
    tick();
  endtask

`ifdef CCC_APB_CFG_READBACK_EN
  task automatic test_readback();
    bif.prdata = 8'h3D;
    issue(1'b1, 6'h15, 8'h3C);
    tick(); tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite, bif.pwdata} !== {1'b1, 1'b1, 1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL rb_wr_access: psel=%b penable=%b pwrite=%b pwdata=%h required 1 1 1 3c",
               bif.psel, bif.penable, bif.pwrite, bif.pwdata);
    end
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite, bif.paddr} !== {1'b1, 1'b0, 1'b0, 6'h15}) begin
      fails++;
      $display("FAIL rb_setup: psel=%b penable=%b pwrite=%b paddr=%h required 1 0 0 15",
               bif.psel, bif.penable, bif.pwrite, bif.paddr);
    end
    tick();
    tests++;
    if ({bif.psel, bif.penable, bif.pwrite} !== 3'b110) begin
      fails++;
      $display("FAIL rb_access: psel=%b penable=%b pwrite=%b required 1 1 0",
               bif.psel, bif.penable, bif.pwrite);
    end
    tick();
    tests++;
    if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {1'b1, 1'b1, 8'h3D}) begin
      fails++;
      $display("FAIL rb_resp: rsp_valid=%b rsp_err=%b rsp_rdata=%h required 1 1 3d",
               bif.rsp_valid, bif.rsp_err, bif.rsp_rdata);
    end
    tick();
  endtask
`endif

  // LOCK high 10 cycles, low 1, then high: first stable after edge 28.
  task automatic test_lock_filter();
    for (int k = 0; k <= 40; k++) begin
      lock = (k == 10) ? 1'b0 : 1'b1;
      tick();
      tests++;
      if (lock_stable !== (k >= 28)) begin
        fails++;
        $display("FAIL lock_filter_e%0d: lock_stable=%b required %b", k, lock_stable, (k >= 28));
      end
    end
  endtask

  task automatic test_lock_loss();
    lock = 1'b0;
    tick(); tick();
    tests++;
    if ({lock_stable, lock_lost} !== 2'b10) begin
      fails++; $display("FAIL loss_sync: stable=%b lost=%b required 1 0", lock_stable, lock_lost);
    end
    tick();
    tests++;
    if ({lock_stable, lock_lost} !== 2'b00) begin
      fails++; $display("FAIL loss_fall: stable=%b lost=%b required 0 0", lock_stable, lock_lost);
    end
    tick();
    tests++;
    if (lock_lost !== 1'b1) begin
      fails++; $display("FAIL loss_set: lost=%b required 1", lock_lost);
    end
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    tests++;
    if (lock_lost !== 1'b0) begin
      fails++; $display("FAIL loss_clr: lost=%b required 0", lock_lost);
    end
    lock = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    tests++;
    if (lock_stable !== 1'b1) begin
      fails++; $display("FAIL relock: stable=%b required 1 after 18 cycles", lock_stable);
    end
    lock = 1'b0;
    tick(); tick(); tick();
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    tests++;
    if (lock_lost !== 1'b1) begin
      fails++; $display("FAIL loss_set_wins: lost=%b required 1", lock_lost);
    end
    tick();
    tests++;
    if (lock_lost !== 1'b1) begin
      fails++; $display("FAIL loss_sticky: lost=%b required 1", lock_lost);
    end
  endtask

  task automatic test_reset_mid_access();
    bif.busy = 1'b0;
    issue(1'b0, 6'h33, 8'h00);
    tick(); tick();
    tests++;
    if ({bif.psel, bif.penable} !== 2'b11) begin
      fails++; $display("FAIL rst_pre_access: psel=%b penable=%b required 1 1", bif.psel, bif.penable);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bif.psel, bif.penable, bif.rsp_valid, bif.cmd_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_async: psel=%b penable=%b rsp_valid=%b cmd_ready=%b required 0 0 0 0",
               bif.psel, bif.penable, bif.rsp_valid, bif.cmd_ready);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({bif.cmd_ready, bif.rsp_valid} !== 2'b10) begin
      fails++;
      $display("FAIL rst_release: cmd_ready=%b rsp_valid=%b required 1 0", bif.cmd_ready, bif.rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({bif.rsp_valid, bif.psel} !== 2'b00) begin
        fails++;
        $display("FAIL rst_no_resp%0d: rsp_valid=%b psel=%b required 0 0", i, bif.rsp_valid, bif.psel);
      end
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.prdata    = '0;
    bif.busy      = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_busy_timeout();
    test_busy_release();
    test_back_to_back();
`ifdef CCC_APB_CFG_READBACK_EN
    test_readback();
`endif
    test_lock_filter();
    test_lock_loss();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccc_apb_cfg_master.md
Name: ccc_apb_cfg_master

Overview:
- APB3-style initiator that drives the dynamic-configuration port of a fabric CCC/PLL (PSEL, PENABLE, PWRITE, PADDR[5:0], PWDATA[7:0], PRDATA[7:0], BUSY).
- Accepts single read/write commands from fabric logic over a valid/ready interface and returns a response.
- Also conditions the CCC LOCK output into a filtered lock-status flag and a sticky lock-loss flag.
- Sits between the system-block control logic and the CCC instance.

Parameters:
- BUSY_TIMEOUT, 255: max cycles to wait for BUSY low before aborting a command; range 1..65535.
- LOCK_FILTER, 16: consecutive synchronized-high LOCK cycles required before LOCK_STABLE asserts; range 1..65535.

Ports:
- PCLK  in  1  single clock for all logic; also the APB PCLK.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  6  CCC register address.
- CMD_WDATA  in  8  write data.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_RDATA  out  8  read data (readback data when the optional feature is enabled).
- RSP_ERR  out  1  BUSY timeout, or readback mismatch when the optional feature is enabled.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- BUSY  in  1  CCC busy (asynchronous to PCLK).
- LOCK  in  1  CCC lock (asynchronous to PCLK).
- LOCK_STABLE  out  1  filtered lock.
- LOCK_LOST  out  1  sticky lock-loss flag.
- LOCK_LOST_CLR  in  1  clears LOCK_LOST.

Behaviour:
- Reset: all outputs are 0. FSM enters IDLE; counters and synchronizers clear. RESET is asynchronous to assert and is released synchronously through the RESET port by the system.
- BUSY and LOCK each pass through a 2-FF synchronizer (BUSY_S, LOCK_S) before use.
- CMD_READY is 1 only in IDLE. On a handshake, CMD_WRITE, CMD_ADDR and CMD_WDATA are captured into holding registers and the FSM moves to WAIT_BUSY.
- WAIT_BUSY:
  - BUSY_S = 0 → SETUP.
  - Otherwise the timeout counter increments; when it reaches BUSY_TIMEOUT → RESP with RSP_ERR = 1, RSP_RDATA = 0, and no APB cycle is issued.
- SETUP (1 cycle): PSEL = 1, PENABLE = 0, PADDR/PWRITE/PWDATA driven from the holding registers.
- ACCESS (1 cycle): PSEL = 1, PENABLE = 1. The CCC port has no PREADY, so every access is exactly 2 cycles. On reads, PRDATA is sampled at the end of ACCESS.
- RESP (1 cycle): RSP_VALID = 1 with RSP_RDATA and RSP_ERR, then → IDLE.
- APB outputs:
  - PSEL/PENABLE are 0 outside SETUP/ACCESS.
  - PADDR/PWRITE/PWDATA hold their last value when idle.
- Latency with BUSY_S low at handshake: handshake cycle N, WAIT_BUSY N+1, SETUP N+2, ACCESS N+3, RSP_VALID N+4. The next command is accepted at N+5 at the earliest.
- Reset mid-access: PSEL/PENABLE drop immediately and no response is issued.
- BUSY rising during SETUP/ACCESS is ignored; BUSY is checked only in WAIT_BUSY.
- Lock filter:
  - A counter increments while LOCK_S = 1 and saturates at LOCK_FILTER. LOCK_STABLE = 1 when counter == LOCK_FILTER.
  - LOCK_S = 0 clears the counter and LOCK_STABLE on the next cycle.
- LOCK_LOST:
  - Set on the falling edge of LOCK_STABLE.
  - Cleared when LOCK_LOST_CLR = 1.
  - If set and clear coincide in the same cycle, set wins.

Optional Feature:
- Macro: CCC_APB_CFG_READBACK_EN.
- Defined: after a write's ACCESS, the FSM inserts RB_SETUP and RB_ACCESS, a read of the same address with PWRITE = 0.
  - RSP_RDATA = readback value.
  - RSP_ERR = 1 if readback ≠ written data.
  - Write latency grows by 2 cycles; reads are unchanged.
- Undefined: writes return RSP_RDATA = 0 and RSP_ERR = 0 (unless a timeout occurred). The RB states are not synthesized.

Decomposition:
- Package ccc_apb_cfg_pkg:
  - FSM state enum: IDLE, WAIT_BUSY, SETUP, ACCESS, RB_SETUP, RB_ACCESS, RESP.
  - Widths: CCC_ADDR_W = 6, CCC_DATA_W = 8.
- Sub-module ccc_lock_monitor: LOCK synchronizer, filter counter, LOCK_STABLE and sticky LOCK_LOST; parameterized by LOCK_FILTER.

Test Plan:
- Write: addr 0x2A, data 0x5C, BUSY = 0 → handshake at cycle N; PSEL at N+2; PENABLE at N+3 with PADDR = 0x2A, PWRITE = 1, PWDATA = 0x5C; RSP_VALID at N+4 with RSP_ERR = 0.
- Read: addr 0x07, PRDATA model returns 0xA5 → RSP_RDATA = 0xA5, RSP_ERR = 0; PWRITE = 0 throughout.
- BUSY held high with BUSY_TIMEOUT = 4 → no PSEL pulse; RSP_VALID with RSP_ERR = 1 after 4 WAIT_BUSY counts. BUSY dropping after 2 cycles instead → normal access.
- LOCK_FILTER = 16: LOCK high for 10 cycles, low 1, then high continuously → LOCK_STABLE stays 0 until 16 consecutive synced-high cycles.
- Lock loss: LOCK_STABLE high, then LOCK low → LOCK_STABLE falls and LOCK_LOST sets. Pulsing LOCK_LOST_CLR in the same cycle as a new loss event → LOCK_LOST stays 1.
- With CCC_APB_CFG_READBACK_EN: write 0x3C, model returns 0x3D → a second APB read to the same address occurs, RSP_RDATA = 0x3D, RSP_ERR = 1.
- Reset during ACCESS: PSEL/PENABLE go to 0 asynchronously, no RSP_VALID, CMD_READY = 1 after release.
